// File: rtl/restoring_div.sv
// Sequential restoring divider: one quotient bit per clock, MSB first, with a
// fixed DW+2 cycle round trip from accepted start to the end of the done pulse.
module restoring_div #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          dbz
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t        state;
    logic [DW-1:0] dr;
    logic [VW-1:0] dvs;
    logic [VW:0]   pr;
    logic [DW-1:0] q;
    logic [CW-1:0] cnt;

    logic [VW+1:0] stp;
    logic [DW-1:0] nq;

    // One restoring step: returns {quotient bit, next partial remainder}.
    function automatic logic [VW+1:0] div_step(input logic [VW:0] p,
                                               input logic        msb,
                                               input logic [VW-1:0] d);
        logic [VW+1:0]        shifted;
        logic signed [VW+2:0] trial;
        shifted = {p, msb};
        trial   = $signed({1'b0, shifted}) - $signed({3'b000, d});
        if (trial >= 0)
            div_step = {1'b1, trial[VW:0]};
        else
            div_step = {1'b0, shifted[VW:0]};
    endfunction

    assign stp = div_step(pr, dr[DW-1], dvs);
    assign nq  = (q << 1) | {{(DW-1){1'b0}}, stp[VW+1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            dr        <= '0;
            dvs       <= '0;
            pr        <= '0;
            q         <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dr    <= dividend;
                        dvs   <= divisor;
                        pr    <= '0;
                        q     <= '0;
                        cnt   <= CW'(DW - 1);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    pr  <= stp[VW:0];
                    dr  <= dr << 1;
                    q   <= nq;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // A zero divisor still runs the full sequence; the result is forced here.
                        if (dvs == '0) begin
                            quotient  <= '1;
                            remainder <= '1;
                            dbz       <= 1'b1;
                        end else begin
                            quotient  <= nq;
                            remainder <= stp[VW-1:0];
                            dbz       <= 1'b0;
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
